// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-2 Booth multiplier.
// Holds the FSM encoding, Booth step op codes and the accumulator width helper.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NOP = 2'd0,
      ADD = 2'd1,
      SUB = 2'd2
   } booth_op_e;

   // Extended operand (WIDTH+1) plus one guard bit so A+/-M cannot overflow.
   function automatic int unsigned calc_xw(input int unsigned width);
      return width + 2;
   endfunction

   function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
      booth_op_e op;
      case ({q0, q_m1})
         2'b01:   op = ADD;
         2'b10:   op = SUB;
         default: op = NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational adder/subtractor slice shared by every Booth iteration.
// Subtraction is a + ~b + 1, with the +1 supplied as the carry-in.
module booth_addsub #(
   parameter int unsigned WIDTH = 10
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH-1:0] w_b;

   assign w_b = sub ? ~b : b;
   assign sum = a + w_b + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one add/sub plus arithmetic shift per cycle,
// valid/ready on both sides, signed or unsigned operands selected per operation.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int unsigned XW = calc_xw(WIDTH);

   state_e           r_state;
   logic [XW-1:0]    r_a;
   logic [XW-1:0]    r_q;
   logic             r_q_m1;
   logic [XW-1:0]    r_m;
   logic [CNT_W-1:0] r_count;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             r_busy;

   booth_op_e        w_op;
   logic [XW-1:0]    w_sum;
   logic [XW-1:0]    w_a_next;
   logic [XW-1:0]    w_m_ext;
   logic [XW-1:0]    w_q_ext;

   assign w_m_ext = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
   assign w_q_ext = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};

   assign w_op = booth_decode(r_q[0], r_q_m1);

   booth_addsub #(
      .WIDTH (XW)
   ) u_addsub (
      .a   (r_a),
      .b   (r_m),
      .sub (w_op == SUB),
      .sum (w_sum)
   );

   assign w_a_next = (w_op == NOP) ? r_a : w_sum;

   // r_count holds remaining steps minus one, so XW always fits in CNT_W bits
   // even when XW is a power of two; the step taken at zero is the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_q         <= '0;
         r_q_m1      <= 1'b0;
         r_m         <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= '0;
                  r_q        <= w_q_ext;
                  r_q_m1     <= 1'b0;
                  r_m        <= w_m_ext;
                  r_count    <= CNT_W'(XW - 1);
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            RUN: begin
               {r_a, r_q, r_q_m1} <= {w_a_next[XW-1], w_a_next, r_q};
               if (r_count == '0) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_count <= r_count - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign product   = r_out_valid ? (2*WIDTH)'({r_a, r_q}) : '0;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq at WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_booth_mult_seq;

   localparam int unsigned WIDTH = 8;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic               signed_mode;
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;

   int n_assert;
   int n_fail;

   booth_mult_seq #(
      .WIDTH (WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents operands for one edge; returns on the falling edge after the accept.
   task automatic start_op(input logic sm, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      signed_mode  = sm;
      multiplicand = m;
      multiplier   = q;
      in_valid     = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
      check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
      check("product_gated_idle", {16'd0, product}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic sm, input logic [WIDTH-1:0] m,
                         input logic [WIDTH-1:0] q, input logic [15:0] exp);
      start_op(sm, m, q);
      wait_done(tag, 10);
      check(tag, {16'd0, product}, {16'd0, exp});
      take();
   endtask

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      signed_mode  = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      out_ready    = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_product", {16'd0, product}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("u_255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
      run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
      run_op("s_m1x1", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
      run_op("u_0xa5", 1'b0, 8'h00, 8'hA5, 16'h0000);
      // 85 * -86 = -7310
      run_op("s_55xaa", 1'b1, 8'h55, 8'hAA, 16'hE372);

      // in_valid pulsed mid-RUN with other operands must not disturb 7 x -3
      start_op(1'b1, 8'h07, 8'hFD);
      @(negedge clk);
      signed_mode  = 1'b0;
      multiplicand = 8'h11;
      multiplier   = 8'h22;
      in_valid     = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("in_ready_low_in_run", {31'd0, in_ready}, 32'd0);
      wait_done("s_7xm3", 8);
      check("s_7xm3", {16'd0, product}, 32'h0000_FFEB);
      take();

      // back-pressure: result held for 20 cycles
      start_op(1'b0, 8'hFF, 8'hFF);
      wait_done("hold", 10);
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_product", {16'd0, product}, 32'h0000_FE01);
      end
      in_valid = 1'b0;
      check("hold_busy", {31'd0, busy}, 32'd1);
      take();

      // asynchronous reset in the middle of RUN
      start_op(1'b0, 8'h09, 8'h09);
      repeat (3) @(negedge clk);
      check("busy_before_reset", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("async_rst_product", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("discarded_out_valid", {31'd0, out_valid}, 32'd0);
      check("discarded_busy", {31'd0, busy}, 32'd0);
      run_op("u_3x5_after_reset", 1'b0, 8'h03, 8'h05, 16'h000F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
